// File: rtl/ama_riscv_spec_ctrl.sv
// Branch speculation controller: tracks one outstanding conditional branch
// from DEC to its resolution in MEM, redirecting fetch and flushing on mispredict.
module ama_riscv_spec_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_br,
  input  logic [31:0] pc_dec,
  input  logic [31:0] br_tgt,
  input  logic        pred,
  input  logic        stall_in,
  input  logic        res_valid,
  input  logic        res_taken,
  output logic        spec_enter,
  output logic        spec_resolve,
  output logic        br_res,
  output logic [31:0] pc_mem,
  output logic        pred_tgt_en,
  output logic [31:0] pred_tgt,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        stall_dec,
  output logic        spec_active,
  output logic        err,
  output logic [31:0] cnt_br,
  output logic [31:0] cnt_mispred
);

  typedef enum logic [1:0] {IDLE, SPEC, RECOVER} state_t;

  state_t      state_q, state_d;
  logic [31:0] s_pc_q, s_pc_d;
  logic [31:0] s_tgt_q, s_tgt_d;
  logic        s_pred_q, s_pred_d;
  logic        err_q, err_d;
  logic [31:0] cnt_br_q, cnt_br_d;
  logic [31:0] cnt_mispred_q, cnt_mispred_d;

  logic in_spec;
  logic resolve;
  logic mispredict;
  logic accept;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    in_spec    = (state_q == SPEC);
    resolve    = in_spec && res_valid;
    mispredict = resolve && (res_taken != s_pred_q);
    // A correct resolve frees the single slot in the same cycle it resolves.
    accept     = dec_br && !stall_in && !mispredict &&
                 ((state_q == IDLE) || (resolve && !mispredict));

    state_d       = state_q;
    s_pc_d        = s_pc_q;
    s_tgt_d       = s_tgt_q;
    s_pred_d      = s_pred_q;
    err_d         = err_q;
    cnt_br_d      = cnt_br_q;
    cnt_mispred_d = cnt_mispred_q;

    case (state_q)
      IDLE:    if (accept) state_d = SPEC;
      SPEC: begin
        if (mispredict)   state_d = RECOVER;
        else if (resolve) state_d = accept ? SPEC : IDLE;
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      s_pc_d   = pc_dec;
      s_tgt_d  = br_tgt;
      s_pred_d = pred;
    end

    if (res_valid && !in_spec) err_d = 1'b1;
    if (resolve)    cnt_br_d      = sat_inc(cnt_br_q);
    if (mispredict) cnt_mispred_d = sat_inc(cnt_mispred_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      s_pc_q        <= 32'd0;
      s_tgt_q       <= 32'd0;
      s_pred_q      <= 1'b0;
      err_q         <= 1'b0;
      cnt_br_q      <= 32'd0;
      cnt_mispred_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      s_pc_q        <= s_pc_d;
      s_tgt_q       <= s_tgt_d;
      s_pred_q      <= s_pred_d;
      err_q         <= err_d;
      cnt_br_q      <= cnt_br_d;
      cnt_mispred_q <= cnt_mispred_d;
    end
  end

  // Outputs are forced quiet while rst is held, even before the first edge clears state.
  assign spec_enter   = accept && !rst;
  assign spec_resolve = resolve && !rst;
  assign br_res       = resolve && res_taken && !rst;
  assign pc_mem       = rst ? 32'd0 : s_pc_q;
  assign pred_tgt_en  = accept && pred && !rst;
  assign pred_tgt     = br_tgt;
  assign flush        = mispredict && !rst;
  assign redirect_pc  = (mispredict && !rst) ?
                        (res_taken ? s_tgt_q : s_pc_q + 32'd4) : 32'd0;
  assign stall_dec    = in_spec && dec_br && !res_valid && !rst;
  assign spec_active  = in_spec && !rst;
  assign err          = err_q && !rst;
  assign cnt_br       = rst ? 32'd0 : cnt_br_q;
  assign cnt_mispred  = rst ? 32'd0 : cnt_mispred_q;

endmodule

// File: tb/tb_ama_riscv_spec_ctrl.sv
// Scoreboard bench for ama_riscv_spec_ctrl: directed scenarios then random
// traffic, checked against a queue-based model of the outstanding branch.
module tb_ama_riscv_spec_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dec_br = 1'b0;
  logic [31:0] pc_dec = 32'd0;
  logic [31:0] br_tgt = 32'd0;
  logic        pred = 1'b0;
  logic        stall_in = 1'b0;
  logic        res_valid = 1'b0;
  logic        res_taken = 1'b0;
  logic        spec_enter, spec_resolve, br_res, pred_tgt_en, flush;
  logic        stall_dec, spec_active, err;
  logic [31:0] pc_mem, pred_tgt, redirect_pc, cnt_br, cnt_mispred;

  ama_riscv_spec_ctrl dut (
    .clk(clk), .rst(rst), .dec_br(dec_br), .pc_dec(pc_dec), .br_tgt(br_tgt),
    .pred(pred), .stall_in(stall_in), .res_valid(res_valid), .res_taken(res_taken),
    .spec_enter(spec_enter), .spec_resolve(spec_resolve), .br_res(br_res),
    .pc_mem(pc_mem), .pred_tgt_en(pred_tgt_en), .pred_tgt(pred_tgt),
    .flush(flush), .redirect_pc(redirect_pc), .stall_dec(stall_dec),
    .spec_active(spec_active), .err(err), .cnt_br(cnt_br), .cnt_mispred(cnt_mispred)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        spec_enter;
    logic        spec_resolve;
    logic        br_res;
    logic [31:0] pc_mem;
    logic        pred_tgt_en;
    logic [31:0] pred_tgt;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        stall_dec;
    logic        spec_active;
    logic        err;
    logic [31:0] cnt_br;
    logic [31:0] cnt_mispred;
  } exp_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        pred;
  } br_t;

  exp_t exp_q[$];
  br_t  outstanding[$];
  logic        recovering = 1'b0;
  logic        m_err = 1'b0;
  logic [31:0] m_cbr = 32'd0;
  logic [31:0] m_cmis = 32'd0;
  logic [31:0] last_pc = 32'd0;
  logic        running = 1'b0;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] sat1(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Drives one cycle of inputs, predicts the outputs, then advances the model.
  task automatic step(input logic r, input logic db, input logic [31:0] pc,
                      input logic [31:0] tg, input logic pr, input logic st,
                      input logic rv, input logic rt);
    exp_t e;
    br_t  o;
    logic has, resolving, wrong, enter;
    @(posedge clk);
    #1;
    rst = r; dec_br = db; pc_dec = pc; br_tgt = tg; pred = pr;
    stall_in = st; res_valid = rv; res_taken = rt;
    running = 1'b1;
    e = '0;
    e.rst = r;
    e.pred_tgt = tg;
    if (r) begin
      exp_q.push_back(e);
      outstanding.delete();
      recovering = 1'b0; m_err = 1'b0; m_cbr = 32'd0; m_cmis = 32'd0; last_pc = 32'd0;
    end else begin
      has = (outstanding.size() != 0);
      o = has ? outstanding[0] : '0;
      resolving = has && rv;
      wrong = resolving && (rt != o.pred);
      enter = db && !st && !wrong && !recovering && (!has || resolving);
      e.spec_enter   = enter;
      e.spec_resolve = resolving;
      e.br_res       = resolving && rt;
      e.pc_mem       = last_pc;
      e.pred_tgt_en  = enter && pr;
      e.flush        = wrong;
      e.redirect_pc  = wrong ? (rt ? o.tgt : o.pc + 32'd4) : 32'd0;
      e.stall_dec    = has && db && !rv;
      e.spec_active  = has;
      e.err          = m_err;
      e.cnt_br       = m_cbr;
      e.cnt_mispred  = m_cmis;
      exp_q.push_back(e);
      if (rv && !has) m_err = 1'b1;
      if (resolving) begin
        m_cbr = sat1(m_cbr);
        void'(outstanding.pop_front());
      end
      if (wrong) m_cmis = sat1(m_cmis);
      recovering = wrong;
      if (enter) begin
        outstanding.push_back('{pc: pc, tgt: tg, pred: pr});
        last_pc = pc;
      end
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (running) begin
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
        end else begin
          e = exp_q.pop_front();
          chk("spec_enter",   {31'd0, spec_enter},   {31'd0, e.spec_enter});
          chk("spec_resolve", {31'd0, spec_resolve}, {31'd0, e.spec_resolve});
          if (e.spec_resolve || e.rst) chk("br_res", {31'd0, br_res}, {31'd0, e.br_res});
          chk("pc_mem",       pc_mem,                e.pc_mem);
          chk("pred_tgt_en",  {31'd0, pred_tgt_en},  {31'd0, e.pred_tgt_en});
          chk("pred_tgt",     pred_tgt,              e.pred_tgt);
          chk("flush",        {31'd0, flush},        {31'd0, e.flush});
          chk("redirect_pc",  redirect_pc,           e.redirect_pc);
          chk("stall_dec",    {31'd0, stall_dec},    {31'd0, e.stall_dec});
          chk("spec_active",  {31'd0, spec_active},  {31'd0, e.spec_active});
          chk("err",          {31'd0, err},          {31'd0, e.err});
          chk("cnt_br",       cnt_br,                e.cnt_br);
          chk("cnt_mispred",  cnt_mispred,           e.cnt_mispred);
        end
      end
    end
  end

  initial begin
    logic [31:0] pc, tg;
    // reset held across edges
    step(1, 0, 32'h0, 32'h55, 0, 0, 0, 0);
    step(1, 1, 32'h10, 32'h20, 1, 0, 1, 1);
    // enter predicted taken, then mispredict with a competing dec_br
    step(0, 1, 32'h100, 32'h140, 1, 0, 0, 0);
    step(0, 1, 32'h180, 32'h1C0, 1, 0, 1, 0);
    step(0, 1, 32'h184, 32'h1C4, 1, 0, 0, 0);
    // enter, stall three cycles, correct resolve with back-to-back entry
    step(0, 1, 32'h300, 32'h340, 0, 0, 0, 0);
    step(0, 1, 32'h304, 32'h344, 0, 0, 0, 0);
    step(0, 1, 32'h304, 32'h344, 0, 0, 0, 0);
    step(0, 1, 32'h304, 32'h344, 0, 0, 0, 0);
    step(0, 1, 32'h200, 32'h240, 1, 0, 1, 0);
    step(0, 0, 32'h0, 32'h0, 0, 1, 1, 1);
    // wrap of the fall-through PC, then res_valid while idle
    step(0, 1, 32'hFFFF_FFFC, 32'h1000, 1, 0, 0, 0);
    step(0, 0, 32'h0, 32'h0, 0, 0, 1, 0);
    step(0, 0, 32'h0, 32'h0, 0, 0, 1, 1);
    step(0, 0, 32'h0, 32'h0, 0, 0, 1, 1);
    step(0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
    // reset mid-speculation, then res_valid with nothing outstanding
    step(0, 1, 32'h400, 32'h440, 1, 0, 0, 0);
    step(1, 0, 32'h0, 32'h0, 0, 0, 0, 0);
    step(0, 0, 32'h0, 32'h0, 0, 0, 1, 1);
    step(0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      tg = $urandom;
      step(($urandom_range(0, 63) == 0), $urandom_range(0, 1), pc, tg,
           $urandom_range(0, 1), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 9) < 4), $urandom_range(0, 1));
    end
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++; checks++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
